// File: rtl/mini68k_pfq.sv
// mini68k_pfq - instruction prefetch queue for the mini68k core.
//
// Keeps a DEPTH-word circular queue of 16-bit instruction words filled ahead
// of the decoder. Words arrive from the bus interface unit over a req/done
// handshake. The decoder sees the three words at the head and retires 1..3
// of them per cycle. A flush empties the queue and redirects fetching. A bus
// cycle that is already in flight at flush time still completes, but its data
// is thrown away.
//
// Optional feature macro: MINI68K_PFQ_STATS_EN
//   When defined, the stall_cnt and drop_cnt statistics ports are added.
//
// Parameters:
//   DEPTH       queue depth in words (power of 2, >= 4)
//   ADDR_W      fetch address width
//   RESET_ADDR  first fetch address after reset (bit 0 ignored)
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         discard the queue and redirect fetching to flush_pc
//   flush_pc      redirect address (bit 0 forced to 0)
//   fetch_addr    word address of the current bus request
//   fetch_req     bus request, held until fetch_done
//   fetch_data    fetched word, valid with fetch_done
//   fetch_done    one-cycle completion strobe
//   ir/ext1/ext2  queue words at head, head+1, head+2
//   valid_words   words available at head, saturated at 3
//   ir_valid      at least one word available
//   stall_cnt     (stats only) cycles in which consume_len exceeded the queue count
//   drop_cnt      (stats only) words discarded after a flush
//   consume_len   number of words retired this cycle (0 = none)
module mini68k_pfq #(
    parameter int                 DEPTH      = 4,
    parameter int                 ADDR_W     = 24,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_req,
    input  logic [15:0]       fetch_data,
    input  logic              fetch_done,
    output logic [15:0]       ir,
    output logic [15:0]       ext1,
    output logic [15:0]       ext2,
    output logic [2:0]        valid_words,
    output logic              ir_valid,
`ifdef MINI68K_PFQ_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [7:0]        drop_cnt,
`endif
    input  logic [1:0]        consume_len
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_WORD = RESET_ADDR & ~ADDR_W'(1);

    // DROP: a flush arrived while a bus cycle was outstanding. The request is
    // kept up on the old address until it completes, and the redirect target
    // waits in redirect_q.
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]   redirect_q, redirect_d;
    logic [15:0]         mem_q [DEPTH];
    logic [15:0]         mem_d [DEPTH];

    logic                write_en;
    logic                consume_ok;
    logic [CNT_W-1:0]    consume_w;
    logic [ADDR_W-1:0]   pc_aligned;

    always_comb begin
        pc_aligned = flush_pc & ~ADDR_W'(1);
        consume_w  = CNT_W'(consume_len);
        // An over-long consume is dropped as a whole; the head never moves partially.
        consume_ok = !flush && (consume_len != 2'd0) && (consume_w <= count_q);
        // Only a normal REQ completion stores data; DROP completions and
        // completions that coincide with a flush are discarded.
        write_en   = fetch_done && (state_q == REQ) && !flush;

        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fetch_addr_d = fetch_addr_q;
        redirect_d   = redirect_q;
        mem_d        = mem_q;

        count_d = count_q + CNT_W'(write_en) - (consume_ok ? consume_w : '0);
        if (consume_ok) begin
            head_d = head_q + PTR_W'(consume_len);
        end
        if (write_en) begin
            mem_d[tail_q] = fetch_data;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        // A new request is issued only when the slot it fills is already
        // free after this cycle's update, so the queue can never overrun.
        case (state_q)
            IDLE: begin
                if (flush) begin
                    fetch_addr_d = pc_aligned;
                    state_d      = REQ;
                end else if (count_d != DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    if (fetch_done) begin
                        fetch_addr_d = pc_aligned;
                        state_d      = REQ;
                    end else begin
                        redirect_d = pc_aligned;
                        state_d    = DROP;
                    end
                end else if (fetch_done) begin
                    fetch_addr_d = fetch_addr_q + ADDR_W'(2);
                    state_d      = (count_d != DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (flush) begin
                    redirect_d = pc_aligned;
                end
                if (fetch_done) begin
                    fetch_addr_d = flush ? pc_aligned : redirect_q;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers and queue storage; all entries clear on reset so the
    // head outputs read zero before anything has been fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fetch_addr_q <= RESET_WORD;
            redirect_q   <= RESET_WORD;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            redirect_q   <= redirect_d;
            mem_q        <= mem_d;
        end
    end

    assign fetch_req   = (state_q != IDLE);
    assign fetch_addr  = fetch_addr_q;
    assign ir          = mem_q[head_q];
    assign ext1        = mem_q[head_q + PTR_W'(1)];
    assign ext2        = mem_q[head_q + PTR_W'(2)];
    assign valid_words = (count_q >= CNT_W'(3)) ? 3'd3 : 3'(count_q);
    assign ir_valid    = (count_q != '0);

`ifdef MINI68K_PFQ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // Saturating statistics, cleared only by reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if ((consume_w > count_q) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((state_q == DROP) && fetch_done && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mini68k_pfq.sv
// tb_mini68k_pfq - self-checking bench for mini68k_pfq (DEPTH=4, RESET_ADDR=0x100).
//
// Every bus handshake is checked against a queue of expected fetch addresses
// by an independent monitor process. Queue contents are checked with directed
// expectations, and the wrap run uses a small reference queue of fetched words.
// The bus answers every request with data 0xC000 | addr[11:0].
module tb_mini68k_pfq;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] flush_pc = '0;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_req;
    logic [15:0]       fetch_data = '0;
    logic              fetch_done = 1'b0;
    logic [15:0]       ir;
    logic [15:0]       ext1;
    logic [15:0]       ext2;
    logic [2:0]        valid_words;
    logic              ir_valid;
    logic [1:0]        consume_len = '0;
`ifdef MINI68K_PFQ_STATS_EN
    logic [15:0]       stall_cnt;
    logic [7:0]        drop_cnt;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [15:0]       model_q [$];

    mini68k_pfq #(
        .DEPTH      (4),
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (24'h100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_addr  (fetch_addr),
        .fetch_req   (fetch_req),
        .fetch_data  (fetch_data),
        .fetch_done  (fetch_done),
        .ir          (ir),
        .ext1        (ext1),
        .ext2        (ext2),
        .valid_words (valid_words),
        .ir_valid    (ir_valid),
`ifdef MINI68K_PFQ_STATS_EN
        .stall_cnt   (stall_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .consume_len (consume_len)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge
    // take them, then return the inputs to idle shortly after that edge.
    task automatic applyStimulus(input logic done, input logic [1:0] len,
                                 input logic fl, input logic [ADDR_W-1:0] pc);
        @(negedge clk);
        fetch_done  = done;
        consume_len = len;
        flush       = fl;
        flush_pc    = pc;
        fetch_data  = 16'hC000 | {4'h0, fetch_addr[11:0]};
        @(posedge clk);
        #1;
        fetch_done  = 1'b0;
        consume_len = 2'd0;
        flush       = 1'b0;
    endtask

    // Bus-side monitor: every completed handshake must match the next
    // expected request address.
    always begin
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        #3;
        if (rst_n && fetch_req && fetch_done) begin
            if (exp_addr_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_fetch: got addr 0x%0h, expected no request", fetch_addr);
            end else begin
                exp_addr = exp_addr_q.pop_front();
                checkOutput("fetch_addr", 32'(fetch_addr), 32'(exp_addr));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               issued;
        int               retired;
        int               pat;
        int               cyc;
        int               exp_valid;
        logic             d;
        logic [1:0]       cl;
        logic [ADDR_W-1:0] a;
        logic [1:0]       lens [3];

        lens = '{2'd1, 2'd2, 2'd3};

        // Reset values
        #12;
        checkOutput("reset_fetch_req", 32'(fetch_req), 32'd0);
        checkOutput("reset_fetch_addr", 32'(fetch_addr), 32'h100);
        checkOutput("reset_valid_words", 32'(valid_words), 32'd0);
        checkOutput("reset_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("reset_ir", 32'(ir), 32'd0);
        checkOutput("reset_ext1", 32'(ext1), 32'd0);
        checkOutput("reset_ext2", 32'(ext2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE -> REQ on the first edge out of reset
        applyStimulus(1'b0, 2'd0, 1'b0, '0);
        checkOutput("first_req", 32'(fetch_req), 32'd1);
        checkOutput("first_addr", 32'(fetch_addr), 32'h100);

        // Fill the queue with done every cycle
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(24'h100 + 24'(2 * i));
            applyStimulus(1'b1, 2'd0, 1'b0, '0);
            checkOutput("fill_valid", 32'(valid_words), (i >= 2) ? 32'd3 : 32'(i + 1));
        end
        checkOutput("fill_req_drop", 32'(fetch_req), 32'd0);
        checkOutput("fill_ir", 32'(ir), 32'hC100);
        checkOutput("fill_ext1", 32'(ext1), 32'hC102);
        checkOutput("fill_ext2", 32'(ext2), 32'hC104);

        // Consume 3 of 4
        applyStimulus(1'b0, 2'd3, 1'b0, '0);
        checkOutput("c3_ir", 32'(ir), 32'hC106);
        checkOutput("c3_valid", 32'(valid_words), 32'd1);
        checkOutput("c3_req", 32'(fetch_req), 32'd1);
        checkOutput("c3_addr", 32'(fetch_addr), 32'h108);

        // Grow to 2, then consume and fetch in the same cycle
        exp_addr_q.push_back(24'h108);
        applyStimulus(1'b1, 2'd0, 1'b0, '0);
        checkOutput("grow_valid", 32'(valid_words), 32'd2);
        checkOutput("grow_ext1", 32'(ext1), 32'hC108);
        exp_addr_q.push_back(24'h10A);
        applyStimulus(1'b1, 2'd1, 1'b0, '0);
        checkOutput("sim_valid", 32'(valid_words), 32'd2);
        checkOutput("sim_ir", 32'(ir), 32'hC108);
        checkOutput("sim_ext1", 32'(ext1), 32'hC10A);

        // Illegal consume is ignored entirely
        applyStimulus(1'b0, 2'd1, 1'b0, '0);
        checkOutput("pre_ill_ir", 32'(ir), 32'hC10A);
        applyStimulus(1'b0, 2'd2, 1'b0, '0);
        checkOutput("ill_ir", 32'(ir), 32'hC10A);
        checkOutput("ill_valid", 32'(valid_words), 32'd1);
        checkOutput("ill_addr", 32'(fetch_addr), 32'h10C);
`ifdef MINI68K_PFQ_STATS_EN
        checkOutput("ill_stall_cnt", 32'(stall_cnt), 32'd1);
`endif

        // Flush with a fetch in flight: old address held, data dropped
        applyStimulus(1'b0, 2'd0, 1'b1, 24'h201);
        checkOutput("fl_valid", 32'(valid_words), 32'd0);
        checkOutput("fl_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("fl_req", 32'(fetch_req), 32'd1);
        checkOutput("fl_old_addr", 32'(fetch_addr), 32'h10C);
        exp_addr_q.push_back(24'h10C);
        applyStimulus(1'b1, 2'd0, 1'b0, '0);
        checkOutput("drop_valid", 32'(valid_words), 32'd0);
        checkOutput("drop_redirect", 32'(fetch_addr), 32'h200);

        // Repeated flush during DROP keeps the newest target
        applyStimulus(1'b0, 2'd0, 1'b1, 24'h300);
        checkOutput("fl2_addr", 32'(fetch_addr), 32'h200);
        applyStimulus(1'b0, 2'd0, 1'b1, 24'h400);
        checkOutput("fl3_addr", 32'(fetch_addr), 32'h200);
        exp_addr_q.push_back(24'h200);
        applyStimulus(1'b1, 2'd0, 1'b0, '0);
        checkOutput("fl3_valid", 32'(valid_words), 32'd0);
        checkOutput("fl3_redirect", 32'(fetch_addr), 32'h400);
        exp_addr_q.push_back(24'h400);
        applyStimulus(1'b1, 2'd0, 1'b0, '0);
        checkOutput("post_fl_valid", 32'(valid_words), 32'd1);
        checkOutput("post_fl_ir", 32'(ir), 32'hC400);
`ifdef MINI68K_PFQ_STATS_EN
        checkOutput("drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // Flush coincident with done in REQ: redirect immediately
        exp_addr_q.push_back(24'h402);
        applyStimulus(1'b1, 2'd0, 1'b1, 24'h600);
        checkOutput("fld_valid", 32'(valid_words), 32'd0);
        checkOutput("fld_req", 32'(fetch_req), 32'd1);
        checkOutput("fld_addr", 32'(fetch_addr), 32'h600);

        // Wrap: 12 words through the queue with consume lengths 1,2,3
        issued  = 0;
        retired = 0;
        pat     = 0;
        cyc     = 0;
        while (retired < 12 && cyc < 200) begin
            d  = fetch_req && (issued < 12);
            cl = (model_q.size() >= int'(lens[pat])) ? lens[pat] : 2'd0;
            if (cl != 2'd0) begin
                for (int k = 0; k < int'(cl); k++) begin
                    void'(model_q.pop_front());
                end
                retired += int'(cl);
                pat = (pat + 1) % 3;
            end
            if (d) begin
                a = 24'h600 + 24'(2 * issued);
                exp_addr_q.push_back(a);
                model_q.push_back(16'hC000 | {4'h0, a[11:0]});
                issued++;
            end
            applyStimulus(d, cl, 1'b0, '0);
            cyc++;
            exp_valid = (model_q.size() > 3) ? 3 : model_q.size();
            checkOutput("wrap_valid", 32'(valid_words), 32'(exp_valid));
            if (model_q.size() > 0) begin
                checkOutput("wrap_ir", 32'(ir), 32'(model_q[0]));
            end
            if (model_q.size() > 1) begin
                checkOutput("wrap_ext1", 32'(ext1), 32'(model_q[1]));
            end
        end
        checkOutput("wrap_retired", 32'(retired), 32'd12);

        repeat (2) @(negedge clk);
        checkOutput("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
